// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: column drive, row sync, frame debounce and press events with valid/ready.
// Optional auto-repeat compiled in when AUTO_REPEAT_EN is defined.
module keypad_scan_ctrl #(
  parameter int unsigned SCAN_DIV       = 4,
  parameter int unsigned DEBOUNCE_SCANS = 3,
  parameter int unsigned REPEAT_DELAY   = 32,
  parameter int unsigned REPEAT_RATE    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  rows_n,
  output logic [3:0]  cols_n,
  output logic [15:0] buttons,
  output logic        key_valid,
  output logic [4:0]  key_code,
  input  logic        key_ready,
  output logic        overrun
);

  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CntW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {StCol0, StCol1, StCol2, StCol3} state_e;

  state_e          r_state, w_state_next;
  logic [DivW-1:0] r_div;
  logic [3:0]      r_cols_n, w_cols_next;
  logic [3:0]      r_rows_meta, r_rows_sync;
  logic [15:0]     r_raw, w_raw_next;
  logic [15:0]     r_prev;
  logic [CntW-1:0] r_stable_cnt, w_cnt_next;
  logic            r_commit;
  logic [15:0]     r_buttons, r_btn_prev;
  logic            r_key_valid;
  logic [4:0]      r_key_code;
  logic            r_overrun;
  logic            w_col_last, w_frame_end, w_same;
  logic [15:0]     w_inv;
  logic            w_single, w_press_evt, w_rep_evt, w_event, w_accept;
  logic [3:0]      w_idx;

  // Rows are asynchronous to clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rows_meta <= 4'hF;
      r_rows_sync <= 4'hF;
    end else begin
      r_rows_meta <= rows_n;
      r_rows_sync <= r_rows_meta;
    end
  end

  assign w_col_last  = (r_div == DivLast);
  assign w_frame_end = w_col_last && (r_state == StCol3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StCol0;
      r_div    <= '0;
      r_cols_n <= 4'b1110;
    end else begin
      r_state  <= w_state_next;
      r_div    <= w_col_last ? '0 : r_div + DivW'(1);
      r_cols_n <= w_cols_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cols_next  = 4'b1110;
    unique case (r_state)
      StCol0:  if (w_col_last) w_state_next = StCol1;
      StCol1:  if (w_col_last) w_state_next = StCol2;
      StCol2:  if (w_col_last) w_state_next = StCol3;
      StCol3:  if (w_col_last) w_state_next = StCol0;
      default: w_state_next = StCol0;
    endcase
    // Registered column drive keeps cols_n glitch-free.
    unique case (w_state_next)
      StCol0:  w_cols_next = 4'b1110;
      StCol1:  w_cols_next = 4'b1101;
      StCol2:  w_cols_next = 4'b1011;
      StCol3:  w_cols_next = 4'b0111;
      default: w_cols_next = 4'b1110;
    endcase
  end

  always_comb begin
    w_raw_next = r_raw;
    if (w_col_last) begin
      unique case (r_state)
        StCol0:  w_raw_next[3:0]   = r_rows_sync;
        StCol1:  w_raw_next[7:4]   = r_rows_sync;
        StCol2:  w_raw_next[11:8]  = r_rows_sync;
        StCol3:  w_raw_next[15:12] = r_rows_sync;
        default: w_raw_next = r_raw;
      endcase
    end
  end

  // The frame compared at frame end includes the column-3 nibble captured in that same cycle.
  assign w_same = (w_raw_next == r_prev);

  always_comb begin
    w_cnt_next = CntW'(1);
    if (w_same) begin
      w_cnt_next = (r_stable_cnt == CntMax) ? CntMax : r_stable_cnt + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_raw        <= 16'hFFFF;
      r_prev       <= 16'hFFFF;
      r_stable_cnt <= '0;
      r_commit     <= 1'b0;
      r_buttons    <= 16'hFFFF;
      r_btn_prev   <= 16'hFFFF;
    end else begin
      r_raw      <= w_raw_next;
      r_commit   <= 1'b0;
      r_btn_prev <= r_buttons;
      if (w_frame_end) begin
        r_stable_cnt <= w_cnt_next;
        r_prev       <= w_raw_next;
        r_commit     <= (w_cnt_next == CntMax);
      end
      if (r_commit) begin
        r_buttons <= r_raw;
      end
    end
  end

  assign w_inv    = ~r_buttons;
  assign w_single = (w_inv != 16'h0000) && ((w_inv & (w_inv - 16'd1)) == 16'h0000);

  always_comb begin
    w_idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (w_inv[i]) w_idx = 4'(i);
    end
  end

  // A press event needs the all-released vector immediately before the single-key one.
  assign w_press_evt = w_single && (r_btn_prev == 16'hFFFF);

`ifdef AUTO_REPEAT_EN
  localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RepW   = $clog2(RepMax + 1);

  logic [RepW-1:0] r_rep_cnt, w_rep_target;
  logic            r_rep_first;
  logic            r_rep_evt;

  assign w_rep_target = r_rep_first ? RepW'(REPEAT_DELAY) : RepW'(REPEAT_RATE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b1;
      r_rep_evt   <= 1'b0;
    end else begin
      r_rep_evt <= 1'b0;
      if ((r_buttons != r_btn_prev) || !w_single) begin
        r_rep_cnt   <= '0;
        r_rep_first <= 1'b1;
      end else if (w_frame_end) begin
        if ((r_rep_cnt + RepW'(1)) == w_rep_target) begin
          r_rep_evt   <= 1'b1;
          r_rep_cnt   <= '0;
          r_rep_first <= 1'b0;
        end else begin
          r_rep_cnt <= r_rep_cnt + RepW'(1);
        end
      end
    end
  end

  assign w_rep_evt = r_rep_evt;
`else
  // No repeat hardware; the repeat parameters stay referenced but contribute nothing.
  assign w_rep_evt = 1'b0 & (REPEAT_DELAY != 0) & (REPEAT_RATE != 0);
`endif

  assign w_event  = w_press_evt | w_rep_evt;
  assign w_accept = r_key_valid & key_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_key_valid <= 1'b0;
      r_key_code  <= 5'd0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_event) begin
        if (!r_key_valid || w_accept) begin
          r_key_valid <= 1'b1;
          r_key_code  <= {1'b0, w_idx} + 5'd1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (w_accept) begin
        r_key_valid <= 1'b0;
      end
    end
  end

  assign cols_n    = r_cols_n;
  assign buttons   = r_buttons;
  assign key_valid = r_key_valid;
  assign key_code  = r_key_code;
  assign overrun   = r_overrun;

endmodule
